// File: rtl/arb_pkg.sv
// arb_pkg: mode constants, FSM state encoding and grant-counter width shared by prio_arbiter
package arb_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR = 1;
  localparam int GNT_CNT_W = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;
endpackage

// File: rtl/prio_scan.sv
// prio_scan: combinational search of req downward from start with wrap; ports req,start -> found,idx
module prio_scan #(
  parameter int N = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] c;
  always_comb begin
    found = 1'b0;
    idx = '0;
    c = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = IDX_W'((int'(start) + N - k) % N);
      if (req[c]) begin
        found = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter: registered N-way fixed/round-robin arbiter with held grant; clk,rst,req,gnt_ready -> gnt_valid,gnt_idx,gnt_onehot (+gnt_cnt when ARB_GNT_CNT_EN)
module prio_arbiter
  import arb_pkg::*;
#(
  parameter int N = 8,
  parameter int MODE = MODE_FIXED,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot
`ifdef ARB_GNT_CNT_EN
  ,
  output logic [GNT_CNT_W-1:0] gnt_cnt
`endif
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d, start, win;
  logic accept, scan, found;
  assign accept = state_q == ST_GRANT && gnt_ready;
  assign scan = state_q == ST_IDLE || accept;
  always_comb begin
    last_d = (MODE == MODE_RR && accept) ? idx_q : last_q;
    start = MODE == MODE_RR ? (last_d == '0 ? IDX_W'(N - 1) : last_d - IDX_W'(1)) : IDX_W'(N - 1);
    state_d = scan ? (found ? ST_GRANT : ST_IDLE) : state_q;
    idx_d = scan && found ? win : idx_q;
  end
  prio_scan #(.N(N)) u_scan (
    .req(req),
    .start(start),
    .found(found),
    .idx(win)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      last_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      last_q <= last_d;
    end
  end
  assign gnt_valid = state_q == ST_GRANT;
  assign gnt_idx = idx_q;
  assign gnt_onehot = gnt_valid ? N'(1) << idx_q : '0;
`ifdef ARB_GNT_CNT_EN
  logic [GNT_CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (accept && cnt_q != '1) cnt_q <= cnt_q + GNT_CNT_W'(1);
  end
  assign gnt_cnt = cnt_q;
`endif
endmodule
